// File: rtl/i2c_init_pkg.sv
// Shared types, CSR offsets and helpers for the I2C master CSR init sequencer.
`timescale 1ns/1ps
package i2c_init_pkg;

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_DIS,
    ST_SCLL,
    ST_SCLH,
    ST_SDAH,
    ST_ISER,
    ST_EN,
    ST_DONE,
    ST_DRAIN
  } i2c_init_state_t;

  // Sub-phase of a write state when readback verification is compiled in.
  typedef enum logic [1:0] {
    PH_WRITE,
    PH_READ,
    PH_RESP
  } i2c_rb_phase_t;

  localparam logic [3:0] CSR_CTRL     = 4'h2;
  localparam logic [3:0] CSR_ISER     = 4'h3;
  localparam logic [3:0] CSR_SCL_LOW  = 4'h8;
  localparam logic [3:0] CSR_SCL_HIGH = 4'h9;
  localparam logic [3:0] CSR_SDA_HOLD = 4'hA;

  function automatic logic [3:0] csr_offset(input i2c_init_state_t s);
    case (s)
      ST_DIS:  return CSR_CTRL;
      ST_SCLL: return CSR_SCL_LOW;
      ST_SCLH: return CSR_SCL_HIGH;
      ST_SDAH: return CSR_SDA_HOLD;
      ST_ISER: return CSR_ISER;
      ST_EN:   return CSR_CTRL;
      default: return 4'h0;
    endcase
  endfunction

  function automatic i2c_init_state_t state_after(input i2c_init_state_t s);
    case (s)
      ST_DIS:  return ST_SCLL;
      ST_SCLL: return ST_SCLH;
      ST_SCLH: return ST_SDAH;
      ST_SDAH: return ST_ISER;
      ST_ISER: return ST_EN;
      ST_EN:   return ST_DONE;
      default: return ST_WAIT;
    endcase
  endfunction

  // Saturating 0..3 outstanding-read counter with simultaneous inc/dec cancelling.
  function automatic logic [1:0] track_reads(input logic [1:0] cnt, input logic inc,
                                             input logic dec);
    if (inc && !dec && cnt != 2'd3) return cnt + 2'd1;
    if (dec && !inc && cnt != 2'd0) return cnt - 2'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/i2c_csr_init_seq.sv
// Programs the I2C master CSRs after reset, then hands the CSR port to the host.
// Optional readback verification of the timing registers: I2C_INIT_READBACK_EN.
`timescale 1ns/1ps
module i2c_csr_init_seq
  import i2c_init_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned START_DELAY  = 16,
  parameter logic [31:0] SCL_LOW_VAL  = 32'd250,
  parameter logic [31:0] SCL_HIGH_VAL = 32'd250,
  parameter logic [31:0] SDA_HOLD_VAL = 32'd60,
  parameter logic [31:0] ISER_VAL     = 32'h0,
  parameter logic [31:0] CTRL_VAL     = 32'h1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reinit,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic                  host_write,
  input  logic                  host_read,
  input  logic [DATA_WIDTH-1:0] host_writedata,
  output logic [DATA_WIDTH-1:0] host_readdata,
  output logic                  host_readdatavalid,
  output logic                  host_waitrequest,
  output logic [ADDR_WIDTH-1:0] i2c_csr_address,
  output logic                  i2c_csr_write,
  output logic                  i2c_csr_read,
  output logic [DATA_WIDTH-1:0] i2c_csr_writedata,
  input  logic [DATA_WIDTH-1:0] i2c_csr_readdata,
  input  logic                  i2c_csr_readdatavalid,
  input  logic                  i2c_csr_waitrequest,
  output logic                  init_done,
  output logic                  init_error
);

  i2c_init_state_t       state, state_next;
  logic [15:0]           delay_cnt, delay_cnt_next;
  logic [1:0]            outstanding, outstanding_next;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [DATA_WIDTH-1:0] seq_data;

`ifdef I2C_INIT_READBACK_EN
  i2c_rb_phase_t phase, phase_next;
  logic          error_q, error_next;
  logic          needs_rb;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_WAIT;
      delay_cnt   <= '0;
      outstanding <= '0;
`ifdef I2C_INIT_READBACK_EN
      phase       <= PH_WRITE;
      error_q     <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      delay_cnt   <= delay_cnt_next;
      outstanding <= outstanding_next;
`ifdef I2C_INIT_READBACK_EN
      phase       <= phase_next;
      error_q     <= error_next;
`endif
    end
  end

  always_comb begin
    state_next       = state;
    delay_cnt_next   = delay_cnt;
    outstanding_next = outstanding;
`ifdef I2C_INIT_READBACK_EN
    phase_next       = phase;
    error_next       = error_q;
    needs_rb         = (state == ST_SCLL) || (state == ST_SCLH) || (state == ST_SDAH);
`endif

    seq_addr = ADDR_WIDTH'(csr_offset(state));
    case (state)
      ST_SCLL: seq_data = DATA_WIDTH'(SCL_LOW_VAL);
      ST_SCLH: seq_data = DATA_WIDTH'(SCL_HIGH_VAL);
      ST_SDAH: seq_data = DATA_WIDTH'(SDA_HOLD_VAL);
      ST_ISER: seq_data = DATA_WIDTH'(ISER_VAL);
      ST_EN:   seq_data = DATA_WIDTH'(CTRL_VAL);
      default: seq_data = '0;
    endcase

    i2c_csr_address    = seq_addr;
    i2c_csr_write      = 1'b0;
    i2c_csr_read       = 1'b0;
    i2c_csr_writedata  = seq_data;
    host_readdata      = i2c_csr_readdata;
    host_readdatavalid = 1'b0;
    host_waitrequest   = 1'b1;

    case (state)
      ST_WAIT: begin
        if (delay_cnt == 16'(START_DELAY - 1)) begin
          state_next     = ST_DIS;
          delay_cnt_next = '0;
        end else begin
          delay_cnt_next = delay_cnt + 16'd1;
        end
      end

      ST_DIS, ST_SCLL, ST_SCLH, ST_SDAH, ST_ISER, ST_EN: begin
`ifdef I2C_INIT_READBACK_EN
        // Timing registers get write, read, wait-for-data before the state advances.
        case (phase)
          PH_WRITE: begin
            i2c_csr_write = 1'b1;
            if (!i2c_csr_waitrequest) begin
              if (needs_rb) phase_next = PH_READ;
              else          state_next = state_after(state);
            end
          end
          PH_READ: begin
            i2c_csr_read = 1'b1;
            if (!i2c_csr_waitrequest) phase_next = PH_RESP;
          end
          default: begin
            if (i2c_csr_readdatavalid) begin
              if (i2c_csr_readdata != seq_data) error_next = 1'b1;
              phase_next = PH_WRITE;
              state_next = state_after(state);
            end
          end
        endcase
`else
        i2c_csr_write = 1'b1;
        if (!i2c_csr_waitrequest) state_next = state_after(state);
`endif
      end

      ST_DONE: begin
        i2c_csr_address    = host_address;
        i2c_csr_write      = host_write;
        i2c_csr_read       = host_read;
        i2c_csr_writedata  = host_writedata;
        host_readdatavalid = i2c_csr_readdatavalid;
        host_waitrequest   = i2c_csr_waitrequest;
        outstanding_next   = track_reads(outstanding, host_read && !i2c_csr_waitrequest,
                                         i2c_csr_readdatavalid);
        if (reinit) state_next = ST_DRAIN;
      end

      ST_DRAIN: begin
        host_readdatavalid = i2c_csr_readdatavalid;
        outstanding_next   = track_reads(outstanding, 1'b0, i2c_csr_readdatavalid);
        if (outstanding == 2'd0) state_next = ST_DIS;
      end

      default: state_next = ST_WAIT;
    endcase
  end

  assign init_done = (state == ST_DONE);

`ifdef I2C_INIT_READBACK_EN
  assign init_error = error_q;
`else
  assign init_error = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_csr_init_seq.sv
// Scoreboard bench for i2c_csr_init_seq with a simple I2C-master CSR slave model.
`timescale 1ns/1ps
module tb_i2c_csr_init_seq;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reinit = 1'b0;
  logic [AW-1:0] host_address = '0;
  logic          host_write = 1'b0;
  logic          host_read = 1'b0;
  logic [DW-1:0] host_writedata = '0;
  logic [DW-1:0] host_readdata;
  logic          host_readdatavalid;
  logic          host_waitrequest;
  logic [AW-1:0] i2c_csr_address;
  logic          i2c_csr_write;
  logic          i2c_csr_read;
  logic [DW-1:0] i2c_csr_writedata;
  logic [DW-1:0] i2c_csr_readdata = '0;
  logic          i2c_csr_readdatavalid = 1'b0;
  logic          i2c_csr_waitrequest = 1'b0;
  logic          init_done;
  logic          init_error;

  i2c_csr_init_seq #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .START_DELAY(SD)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .reinit               (reinit),
    .host_address         (host_address),
    .host_write           (host_write),
    .host_read            (host_read),
    .host_writedata       (host_writedata),
    .host_readdata        (host_readdata),
    .host_readdatavalid   (host_readdatavalid),
    .host_waitrequest     (host_waitrequest),
    .i2c_csr_address      (i2c_csr_address),
    .i2c_csr_write        (i2c_csr_write),
    .i2c_csr_read         (i2c_csr_read),
    .i2c_csr_writedata    (i2c_csr_writedata),
    .i2c_csr_readdata     (i2c_csr_readdata),
    .i2c_csr_readdatavalid(i2c_csr_readdatavalid),
    .i2c_csr_waitrequest  (i2c_csr_waitrequest),
    .init_done            (init_done),
    .init_error           (init_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  rsp_t        rsp_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hold_left = 0;
  logic [3:0]  hold_addr = '0;
  bit          rand_stall = 0;
  bit          corrupt8 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: stall and read-response driver, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    if (hold_left > 0 && i2c_csr_write && i2c_csr_address == hold_addr) begin
      i2c_csr_waitrequest = 1'b1;
      hold_left--;
    end else begin
      i2c_csr_waitrequest = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      i2c_csr_readdatavalid = 1'b1;
      i2c_csr_readdata      = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      i2c_csr_readdatavalid = 1'b0;
      i2c_csr_readdata      = $urandom;
    end
  end

  // Slave: accept transfers at mid-cycle when the request is stable.
  always @(negedge clk) begin
    if (!reset) begin
      if (i2c_csr_write && !i2c_csr_waitrequest)
        slv_mem[i2c_csr_address] = i2c_csr_writedata;
      if (i2c_csr_read && !i2c_csr_waitrequest)
        rsp_q.push_back('{cyc + 2, (corrupt8 && i2c_csr_address == 4'h8) ? 32'd249
                                                                       : slv_mem[i2c_csr_address]});
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer.
  wr_t         mon_e;
  logic [31:0] mon_rd;
  logic [3:0]  st_addr;
  logic [31:0] st_data;
  bit          prev_pend = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_pend = 0;
    end else begin
      if (prev_pend) begin
        check("stall_write", 32'(i2c_csr_write), 32'd1);
        check("stall_addr", 32'(i2c_csr_address), 32'(st_addr));
        check("stall_data", i2c_csr_writedata, st_data);
      end
      prev_pend = i2c_csr_write && i2c_csr_waitrequest;
      st_addr   = i2c_csr_address;
      st_data   = i2c_csr_writedata;
      if (i2c_csr_write && !i2c_csr_waitrequest) begin
        if (exp_wr.size() == 0) begin
          fail_now($sformatf("unexpected_write addr=%0h data=%0h required=none",
                             i2c_csr_address, i2c_csr_writedata));
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", 32'(i2c_csr_address), 32'(mon_e.addr));
          check("wr_data", i2c_csr_writedata, mon_e.data);
          if (mon_e.cyc >= 0) check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (host_readdatavalid) begin
        if (exp_rd.size() == 0) begin
          fail_now($sformatf("unexpected_readdata data=%0h required=none", host_readdata));
        end else begin
          mon_rd = exp_rd.pop_front();
          check("host_rdata", host_readdata, mon_rd);
        end
      end
    end
  end

  task automatic push_init(input int base);
    logic [3:0]  a[6];
    logic [31:0] d[6];
    int          b;
    a = '{4'h2, 4'h8, 4'h9, 4'hA, 4'h3, 4'h2};
    d = '{32'd0, 32'd250, 32'd250, 32'd60, 32'd0, 32'd1};
    b = base;
`ifdef I2C_INIT_READBACK_EN
    b = -1;
`endif
    for (int i = 0; i < 6; i++) begin
      exp_wr.push_back('{a[i], d[i], (b < 0) ? -1 : b + i});
      ref_mem[a[i]] = d[i];
    end
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input bit chk_stall);
    int n;
    int e;
    n = 0;
    e = exp_cyc;
`ifdef I2C_INIT_READBACK_EN
    e = -1;
`endif
    do begin
      @(negedge clk);
      n++;
      if (chk_stall && !init_done) check("host_stalled", 32'(host_waitrequest), 32'd1);
    end while (!init_done && n < 2000);
    if (!init_done) fail_now({name, "_timeout"});
    else if (e >= 0) check(name, 32'(cyc), 32'(e));
  endtask

  task automatic pulse_reinit();
    @(posedge clk);
    #1 reinit = 1'b1;
    @(posedge clk);
    #1 reinit = 1'b0;
  endtask

  task automatic host_op(input bit is_wr, input logic [3:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    host_address   = a;
    host_write     = is_wr;
    host_read      = !is_wr;
    host_writedata = d;
    if (is_wr) begin
      exp_wr.push_back('{a, d, -1});
      ref_mem[a] = d;
    end else begin
      exp_rd.push_back(ref_mem[a]);
    end
    do begin
      @(negedge clk);
      n++;
    end while (host_waitrequest && n < 1000);
    if (host_waitrequest) fail_now("host_op_timeout");
    @(posedge clk);
    #1;
    host_write = 1'b0;
    host_read  = 1'b0;
  endtask

  initial begin
    int  r;
    int  n;
    bit  seen;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_init_error", 32'(init_error), 32'd0);
    check("rst_host_wait", 32'(host_waitrequest), 32'd1);
    check("rst_host_rdv", 32'(host_readdatavalid), 32'd0);
    check("rst_csr_write", 32'(i2c_csr_write), 32'd0);
    check("rst_csr_read", 32'(i2c_csr_read), 32'd0);

    // Release, exact-cycle sequence, host write held off until DONE, stray reinit ignored
    @(posedge clk);
    #1 reset = 1'b0;
    r = cyc;
    push_init(r + SD);
    host_address   = 4'h5;
    host_writedata = 32'hAB;
    host_write     = 1'b1;
    exp_wr.push_back('{4'h5, 32'hAB, -1});
    ref_mem[5] = 32'hAB;
    pulse_reinit();
    wait_done("done_cycle", r + SD + 6, 1'b1);
    check("done_host_wait", 32'(host_waitrequest), 32'd0);
    @(posedge clk);
    #1 host_write = 1'b0;

    // Host read in flight, then reinit: drain, rerun with SCLH stalled 3 cycles
    host_op(1'b0, 4'h8, '0);
    reinit    = 1'b1;
    hold_addr = 4'h9;
    hold_left = 3;
    push_init(-1);
    @(posedge clk);
    #1 reinit = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      check("drain_host_wait", 32'(host_waitrequest), 32'd1);
      check("drain_init_done", 32'(init_done), 32'd0);
      check("drain_no_write", 32'(i2c_csr_write), 32'd0);
      if (host_readdatavalid) seen = 1;
    end
    if (!seen) fail_now("drain_rdv_timeout");
    wait_done("redone", -1, 1'b0);

    // Reset in the middle of the SDAH write
    hold_addr = 4'hA;
    hold_left = 1000;
    push_init(-1);
    pulse_reinit();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i2c_csr_write && i2c_csr_address == 4'hA) && n < 100);
    if (!(i2c_csr_write && i2c_csr_address == 4'hA)) fail_now("sdah_not_reached");
    #2 reset = 1'b1;
    #1;
    check("abort_write", 32'(i2c_csr_write), 32'd0);
    check("abort_read", 32'(i2c_csr_read), 32'd0);
    check("abort_done", 32'(init_done), 32'd0);
    check("abort_host_wait", 32'(host_waitrequest), 32'd1);
    hold_left = 0;
    exp_wr.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    r = cyc;
    push_init(r + SD);
    wait_done("restart_cycle", r + SD + 6, 1'b1);

    // Random stalls and random host traffic against the reference memory
    rand_stall = 1;
    push_init(-1);
    pulse_reinit();
    wait_done("rand_done", -1, 1'b0);
    for (int i = 0; i < 24; i++)
      host_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    repeat (10) @(negedge clk);
    rand_stall = 0;

`ifdef I2C_INIT_READBACK_EN
    corrupt8 = 1;
    push_init(-1);
    pulse_reinit();
    wait_done("corrupt_done", -1, 1'b0);
    check("init_error_set", 32'(init_error), 32'd1);
    corrupt8 = 0;
    push_init(-1);
    pulse_reinit();
    wait_done("sticky_done", -1, 1'b0);
    check("init_error_sticky", 32'(init_error), 32'd1);
`else
    check("init_error_tied", 32'(init_error), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
